univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal 2..64).
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of the step-count field.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 clear_n  input  1  synchronous clear, active-low.
REQ-006 start  input  1  request a new operation; sampled only in IDLE.
REQ-007 mode  input  3  operation code, captured with start.
REQ-008 amount  input  CNT_W  number of single-bit steps, captured with start.
REQ-009 d  input  WIDTH  parallel load data.
REQ-010 sin_l  input  1  serial-in for the MSB end, sampled on each SHR step.
REQ-011 sin_r  input  1  serial-in for the LSB end, sampled on each SHL step.
REQ-012 q  output  WIDTH  register contents, driven directly from the state flop.
REQ-013 sout_l, sout_r  output  1 each  combinational copies of q[WIDTH-1] and q[0].
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 Mode codes: 0 HOLD, 1 LOAD, 2 SHL (sin_r into bit 0), 3 SHR (sin_l into MSB), 4 ROL, 5 ROR, 6 ASR (MSB replicated), 7 reserved, which behaves as HOLD.
REQ-017 FSM states: IDLE, RUN, DONE; the reset state is IDLE.
REQ-018 IDLE + start: LOAD writes q<=d on the accepting edge and goes to DONE; HOLD and reserved leave q unchanged and go to DONE.
REQ-019 IDLE + start with a shift or rotate mode: capture mode and amount and leave q unchanged; amount=0 goes to DONE; amount>0 goes to RUN.
REQ-020 RUN: each edge performs exactly one step of the captured mode and decrements the count; the edge that performs the last step goes to DONE.
REQ-021 Latency: busy is high for exactly amount cycles, and done is high in the cycle following the last step.
REQ-022 DONE: done=1 for one cycle, q holds, and the next edge returns to IDLE; start is not accepted in DONE.
REQ-023 start while busy or done is ignored, with no queuing.
REQ-024 amount is not clamped; rotates of amount >= WIDTH wrap, and shifts of amount >= WIDTH fully flush with serial-in/sign.
REQ-025 clear_n=0 on any edge: q<=0, FSM to IDLE, count<=0, and no done pulse; this takes priority over start and RUN.
REQ-026 Serial inputs are sampled on the step edge only; changes between steps have no effect.

Reset
REQ-027 reset_n=0 immediately forces q=0, busy=0, done=0, FSM=IDLE, captured mode=HOLD and count=0, independent of clk.
REQ-028 reset_n asserted mid-RUN aborts the operation, and no done follows deassertion.
REQ-029 Operation resumes on the first rising edge after reset_n deasserts.

Structure
REQ-030 Package ush_pkg holds the mode code localparams and the FSM state typedef.
REQ-031 One combinational sub-module, ush_step, computes the next q for a single step from (q, mode, sin_l, sin_r); univ_shift_reg instantiates it once.
REQ-032 The count register is CNT_W bits; no other storage beyond q, the captured mode and the FSM state.

Verification (WIDTH=8)
REQ-033 reset_n pulsed low between edges during RUN amount=5 -> q=0x00, busy=0, done=0 at once, and no done after release.
REQ-034 start, LOAD, d=0xA5 -> q=0xA5 after the accepting edge, done=1 for exactly the next cycle, busy never high.
REQ-035 q=0xA5, start, SHL, amount=3, sin_r=1 -> q steps 0x4B, 0x97, 0x2F; busy high 3 cycles, then done pulse.
REQ-036 q=0x85, start, ASR, amount=2 -> q=0xE1; q=0x3C, ROR, amount=8 -> q=0x3C with busy 8 cycles; amount=0 -> done next cycle, q unchanged.
REQ-037 SHR amount=4 in progress, clear_n low for one edge -> q=0x00, IDLE, and no done; start pulsed mid-RUN -> ignored, with the step count unchanged.

Source files
------------

// File: rtl/ush_pkg.sv
// ush_pkg: shared definitions for the universal shift register.
//   - Mode code localparams (3-bit operation codes captured with start)
//   - FSM state typedef used by univ_shift_reg
package ush_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the codes that iterate in RUN (shifts and rotates).
  function automatic logic is_step_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: command/data bundle of the universal shift register.
//   master: drives start, mode, amount, d, sin_l, sin_r; observes results
//   slave : the register itself; drives q, sout_l, sout_r, busy, done
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, d, sin_l, sin_r,
    input  q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  start, mode, amount, d, sin_l, sin_r,
    output q, sout_l, sout_r, busy, done
  );
endinterface

// File: rtl/ush_step.sv
// ush_step: combinational single-step next value of the shift register.
//   q_i     : current register contents
//   mode_i  : operation code (non-step codes pass q_i through)
//   sin_l_i : bit entering the MSB on SHR
//   sin_r_i : bit entering the LSB on SHL
//   q_o     : contents after one step
module ush_step
  import ush_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] q_o
);

  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_SHL: q_o = {q_i[WIDTH-2:0], sin_r_i};
      MODE_SHR: q_o = {sin_l_i, q_i[WIDTH-1:1]};
      MODE_ROL: q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR: q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ASR: q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default:  q_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with a multi-step sequencer.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   clear_n : synchronous active-low clear (beats start and RUN)
//   bus     : slave side of univ_shift_reg_if (start/mode/amount/d/sin_l/
//             sin_r in; q/sout_l/sout_r/busy/done out)
// A start in IDLE either finishes at once (HOLD/LOAD/reserved, or a step
// mode with amount 0) or enters RUN, where one step is applied per edge
// until the count runs out. DONE lasts one cycle and always returns to IDLE.
module univ_shift_reg
  import ush_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   clear_n,
  univ_shift_reg_if.slave bus
);

  state_t           state_q, state_d;
  logic [2:0]       mode_q,  mode_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] step_q;

  // Steps always use the captured mode, never the live mode input.
  ush_step #(.WIDTH(WIDTH)) u_step (
    .q_i     (q_q),
    .mode_i  (mode_q),
    .sin_l_i (bus.sin_l),
    .sin_r_i (bus.sin_r),
    .q_o     (step_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (!clear_n) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      q_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mode_d = bus.mode;
            if (is_step_mode(bus.mode)) begin
              cnt_d   = bus.amount;
              state_d = (bus.amount == '0) ? ST_DONE : ST_RUN;
            end else begin
              if (bus.mode == MODE_LOAD) q_d = bus.d;
              state_d = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          q_d   = step_q;
          cnt_d = cnt_q - CNT_W'(1);
          // The edge performing the final step leaves RUN.
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.q      = q_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;
  import ush_pkg::*;

  logic clk;
  logic reset_n;
  logic clear_n;

  univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q_fifo[$];
  int         exp_busy_fifo[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_op(input logic [7:0] q_exp, input int busy_exp);
    exp_q_fifo.push_back(q_exp);
    exp_busy_fifo.push_back(busy_exp);
  endtask

  // Monitor: on every done pulse pop one expectation; count busy cycles.
  int run_len = 0;
  always @(posedge clk) begin
    #1;
    if (bus.done) begin
      if (exp_q_fifo.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 q=%0h", bus.q);
      end else begin
        logic [7:0] eq;
        int eb;
        eq = exp_q_fifo.pop_front();
        eb = exp_busy_fifo.pop_front();
        chk("done_q", {56'd0, bus.q}, {56'd0, eq});
        chk("busy_cycles", 64'(run_len), 64'(eb));
      end
      run_len = 0;
    end else if (bus.busy) begin
      run_len++;
    end else begin
      run_len = 0;
    end
  end

  task automatic launch(input logic [2:0] m, input logic [3:0] a, input logic [7:0] dv);
    @(negedge clk);
    bus.mode   = m;
    bus.amount = a;
    bus.d      = dv;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'(n), 64'd0);
    @(negedge clk);
  endtask

  logic [7:0] shl_tab [3];

  initial begin
    shl_tab[0] = 8'h4B;
    shl_tab[1] = 8'h97;
    shl_tab[2] = 8'h2F;
    reset_n    = 1'b0;
    clear_n    = 1'b1;
    bus.start  = 1'b0;
    bus.mode   = MODE_HOLD;
    bus.amount = '0;
    bus.d      = '0;
    bus.sin_l  = 1'b0;
    bus.sin_r  = 1'b0;
    #2;
    chk("reset_q", {56'd0, bus.q}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    #10 reset_n = 1'b1;

    // LOAD 0xA5: done the cycle after acceptance, no busy.
    expect_op(8'hA5, 0);
    launch(MODE_LOAD, 4'd0, 8'hA5);
    chk("load_q", {56'd0, bus.q}, 64'hA5);
    chk("load_done", {63'd0, bus.done}, 64'd1);
    chk("load_sout_l", {63'd0, bus.sout_l}, 64'd1);
    chk("load_sout_r", {63'd0, bus.sout_r}, 64'd1);
    @(negedge clk);
    chk("load_done_off", {63'd0, bus.done}, 64'd0);
    wait_idle();

    // SHL x3 with sin_r=1, intermediate values checked.
    bus.sin_r = 1'b1;
    expect_op(8'h2F, 3);
    launch(MODE_SHL, 4'd3, 8'h00);
    chk("shl_q0", {56'd0, bus.q}, 64'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("shl_step", {56'd0, bus.q}, {56'd0, shl_tab[i]});
    end
    wait_idle();
    bus.sin_r = 1'b0;

    // ASR x2 on 0x85.
    expect_op(8'h85, 0);
    launch(MODE_LOAD, 4'd0, 8'h85);
    wait_idle();
    expect_op(8'hE1, 2);
    launch(MODE_ASR, 4'd2, 8'h00);
    wait_idle();

    // ROR x8 on 0x3C wraps to itself.
    expect_op(8'h3C, 0);
    launch(MODE_LOAD, 4'd0, 8'h3C);
    wait_idle();
    expect_op(8'h3C, 8);
    launch(MODE_ROR, 4'd8, 8'h00);
    wait_idle();

    // amount=0 finishes immediately with q unchanged.
    expect_op(8'h3C, 0);
    launch(MODE_ROL, 4'd0, 8'h00);
    wait_idle();

    // ROL x9 wraps: equivalent to ROL x1.
    expect_op(8'h78, 9);
    launch(MODE_ROL, 4'd9, 8'h00);
    wait_idle();

    // SHR x10 with sin_l=1 flushes to all ones.
    bus.sin_l = 1'b1;
    expect_op(8'hFF, 10);
    launch(MODE_SHR, 4'd10, 8'h00);
    wait_idle();
    bus.sin_l = 1'b0;

    // HOLD and reserved: done next cycle, q unchanged (d must be ignored).
    expect_op(8'hFF, 0);
    launch(MODE_HOLD, 4'd3, 8'h12);
    wait_idle();
    expect_op(8'hFF, 0);
    launch(MODE_RSVD, 4'd3, 8'h34);
    wait_idle();

    // Start mid-RUN is ignored: ROL x4 on 0x01 must still end at 0x10.
    expect_op(8'h01, 0);
    launch(MODE_LOAD, 4'd0, 8'h01);
    wait_idle();
    expect_op(8'h10, 4);
    launch(MODE_ROL, 4'd4, 8'h00);
    bus.mode   = MODE_LOAD;
    bus.amount = 4'd1;
    bus.d      = 8'hFF;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_idle();

    // clear_n during SHR x4: q=0, idle, no done afterwards.
    expect_op(8'hF0, 0);
    launch(MODE_LOAD, 4'd0, 8'hF0);
    wait_idle();
    launch(MODE_SHR, 4'd4, 8'h00);
    @(negedge clk);
    chk("clr_pre_q", {56'd0, bus.q}, 64'h78);
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    chk("clr_q", {56'd0, bus.q}, 64'd0);
    chk("clr_busy", {63'd0, bus.busy}, 64'd0);
    chk("clr_done", {63'd0, bus.done}, 64'd0);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-RUN: immediate effect, no done after release.
    expect_op(8'hFF, 0);
    launch(MODE_LOAD, 4'd0, 8'hFF);
    wait_idle();
    launch(MODE_SHR, 4'd5, 8'h00);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_q", {56'd0, bus.q}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    #1 reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_after_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_after_q", {56'd0, bus.q}, 64'd0);

    // Resumes normally after reset.
    expect_op(8'h5A, 0);
    launch(MODE_LOAD, 4'd0, 8'h5A);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("pending_expectations", 64'(exp_q_fifo.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
